// File: rtl/dsram_resp_pkg.sv
// dsram_resp_pkg: MMIO offsets, default MMIO window base and the byte-lane merge helper
package dsram_resp_pkg;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;
    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_TIMER   = 16'h0004;
    localparam logic [15:0] OFF_SCRATCH = 16'h0008;
    localparam logic [15:0] OFF_WCNT    = 16'h000C;
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] we);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dsram_bank.sv
// dsram_bank: 2^ADDR_W x 32 word RAM with byte-lane writes and a read-first registered output.
//   clk      clock
//   en_i     access this cycle
//   we_i     byte-lane write enables (0 = read)
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  pre-write word of the last access, held while en_i=0
module dsram_bank
    import dsram_resp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[idx_i];
            if (|we_i) mem_q[idx_i] <= merge(mem_q[idx_i], wdata_i, we_i);
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data SRAM port responder with word RAM plus LED/TIMER/SCRATCH/WCNT MMIO window.
//   clk, resetn (async, active-low)
//   data_sram_en/we/addr/wdata  request; we=0 is a read
//   data_sram_rdata             registered read data, one cycle after the request
//   led                         LED register
//   Optional macro DSRAM_RESP_WCNT_EN builds the RAM write-request counter at offset 0x000C.
module data_sram_responder
    import dsram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);
    logic        is_mmio, wr, mmio_wr, ram_en, unused_addr_lsbs;
    logic [15:0] off;
    logic [31:0] ram_rdata, mmio_rd, wcnt_rd;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d, scratch_q, scratch_d, mmio_q, mmio_d;
    logic        sel_q, sel_d;
    assign is_mmio          = data_sram_addr[31:16] == MMIO_BASE[31:16];
    assign off              = {data_sram_addr[15:2], 2'b00};
    assign wr               = |data_sram_we;
    assign mmio_wr          = data_sram_en & is_mmio & wr;
    assign unused_addr_lsbs = ^data_sram_addr[1:0];
    // The RAM has no reset, so requests arriving while resetn is low are gated off here.
    assign ram_en = data_sram_en & ~is_mmio & resetn;
    dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (data_sram_we),
        .idx_i   (data_sram_addr[ADDR_W+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rdata)
    );
`ifdef DSRAM_RESP_WCNT_EN
    logic [31:0] wcnt_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wcnt_q <= '0;
        else if (data_sram_en & ~is_mmio & wr) wcnt_q <= wcnt_q + 32'd1;
    end
    assign wcnt_rd = wcnt_q;
`else
    assign wcnt_rd = '0;
`endif
    always_comb begin
        led_d     = (mmio_wr && off == OFF_LED) ?
                    {data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8],
                     data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0]} : led_q;
        timer_d   = (mmio_wr && off == OFF_TIMER) ? merge(timer_q, data_sram_wdata, data_sram_we) : timer_q + 32'd1;
        scratch_d = (mmio_wr && off == OFF_SCRATCH) ? merge(scratch_q, data_sram_wdata, data_sram_we) : scratch_q;
        mmio_rd   = off == OFF_LED     ? {16'h0, led_q} :
                    off == OFF_TIMER   ? timer_q :
                    off == OFF_SCRATCH ? scratch_q :
                    off == OFF_WCNT    ? wcnt_rd : 32'h0;
        mmio_d    = (data_sram_en & is_mmio) ? mmio_rd : mmio_q;
        sel_d     = data_sram_en ? is_mmio : sel_q;
    end
    // Reset selects the cleared MMIO read register so rdata reads 0 without resetting the RAM output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            mmio_q    <= '0;
            sel_q     <= 1'b1;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            mmio_q    <= mmio_d;
            sel_q     <= sel_d;
        end
    end
    assign data_sram_rdata = sel_q ? mmio_q : ram_rdata;
    assign led             = led_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized self-checking bench against a behavioural model of the responder
module tb_data_sram_responder;
    logic        clk = 0;
    logic        resetn = 0;
    logic        en = 0;
    logic [3:0]  we = 0;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic [31:0] rdata;
    logic [15:0] led;
    int checks = 0;
    int errors = 0;
    longint cyc = 0;
`ifdef DSRAM_RESP_WCNT_EN
    localparam bit WCNT_ON = 1'b1;
`else
    localparam bit WCNT_ON = 1'b0;
`endif
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_tbase, m_scratch, m_wcnt;
    longint      m_tcyc;

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [15:0] rand_hi();
        logic [15:0] h;
        h = 16'($urandom);
        return (h == 16'hBFAF) ? 16'h0001 : h;
    endfunction

    task automatic model_reset();
        m_led = 0; m_tbase = 0; m_scratch = 0; m_wcnt = 0; m_tcyc = cyc;
    endtask

    // One request; compares rdata in the following cycle against the model's pre-write value.
    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input string nm);
        logic [31:0] exp, tmp;
        logic [15:0] off;
        logic known;
        int idx;
        longint e;
        @(negedge clk);
        e = cyc + 1;
        known = 1;
        exp = 0;
        off = {a[15:2], 2'b00};
        idx = int'(a[15:2]);
        if (a[31:16] == 16'hBFAF) begin
            if (off == 16'h0000) exp = {16'h0, m_led};
            else if (off == 16'h0004) exp = m_tbase + 32'(e - 1 - m_tcyc);
            else if (off == 16'h0008) exp = m_scratch;
            else if (off == 16'h000C) exp = WCNT_ON ? m_wcnt : 32'h0;
            if (|w) begin
                if (off == 16'h0000) begin
                    tmp = lanes({16'h0, m_led}, d, {2'b00, w[1:0]});
                    m_led = tmp[15:0];
                end else if (off == 16'h0004) begin
                    m_tbase = lanes(exp, d, w);
                    m_tcyc = e;
                end else if (off == 16'h0008) m_scratch = lanes(m_scratch, d, w);
            end
        end else begin
            known = m_mem.exists(idx);
            if (known) exp = m_mem[idx];
            if (|w) begin
                m_wcnt = m_wcnt + 1;
                if (known || w == 4'hF) m_mem[idx] = lanes(known ? exp : 32'h0, d, w);
            end
        end
        en = 1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        en = 0; we = 0;
        if (known) begin
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL %s: addr=%h rdata=%h expected=%h", nm, a, rdata, exp);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", led); end
        @(negedge clk);
        resetn = 1;
        model_reset();
        req(4'h0, 32'hBFAF_0004, 0, "reset_timer");
        req(4'h0, 32'hBFAF_0008, 0, "reset_scratch");
        req(4'h0, 32'hBFAF_0000, 0, "reset_led_rd");
        req(4'h0, 32'hBFAF_000C, 0, "reset_wcnt");
    endtask

    task automatic test_ram_basic();
        req(4'hF, 32'h0000_0010, 32'hDEADBEEF, "wr_10");
        req(4'h0, 32'h0000_0010, 0, "rd_10");
        req(4'b0010, 32'h0000_0010, 32'h0000_5500, "partial_wr");
        req(4'h0, 32'h0000_0010, 0, "partial_rd");
        checks++;
        if (rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL partial_const: got %h expected DEAD55EF", rdata); end
        req(4'h0, 32'h0003_0010, 0, "alias_rd");
        req(4'hF, 32'h0000_0020, 32'hA5A5A5A5, "wr_20");
        req(4'hF, 32'h0000_0020, 32'h11111111, "read_first");
        req(4'h0, 32'h0000_0020, 0, "b2b_rd_20");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'h11111111) begin errors++; $display("FAIL hold_idle: got %h expected 11111111", rdata); end
    endtask

    task automatic test_mmio();
        req(4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE, "timer_wr");
        repeat (2) @(posedge clk);
        req(4'h0, 32'hBFAF_0004, 0, "timer_wrap");
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap_const: got %h expected 0", rdata); end
        req(4'h3, 32'hBFAF_0000, 32'hFFFF_00AB, "led_wr");
        checks++;
        if (led !== 16'h00AB) begin errors++; $display("FAIL led_out: got %h expected 00ab", led); end
        req(4'h0, 32'hBFAF_0000, 0, "led_rd");
        req(4'hF, 32'h0000_0008, 32'h12345678, "ram_8_wr");
        req(4'hF, 32'hBFAF_0008, 32'hCAFEF00D, "scratch_wr");
        req(4'b0100, 32'hBFAF_0008, 32'h0077_0000, "scratch_lane");
        req(4'h0, 32'hBFAF_0008, 0, "scratch_rd");
        req(4'h0, 32'h0000_0008, 0, "ram_isolated");
        req(4'hF, 32'hBFAF_0010, 32'h55555555, "unmapped_wr");
        req(4'h0, 32'hBFAF_0010, 0, "unmapped_rd");
        req(4'hF, 32'hBFAF_000C, 32'h99999999, "wcnt_wr_ignored");
        req(4'h0, 32'hBFAF_000C, 0, "wcnt_rd");
        req(4'h0, 32'hBFAF_0004, 0, "timer_run");
    endtask

    task automatic test_random();
        logic [13:0] pool [8];
        logic [3:0] w;
        int k;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 14'($urandom_range(64, 16383));
            req(4'hF, {rand_hi(), pool[i], 2'b00}, $urandom, "rand_init");
        end
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 7);
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            req(w, {rand_hi(), pool[k], 2'b00}, $urandom, "rand_ram");
            if ($urandom_range(0, 3) == 0) req(4'($urandom), 32'hBFAF_0008, $urandom, "rand_scratch");
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        req(4'h0, 32'hBFAF_0004, 0, "rand_timer");
    endtask

    task automatic test_reset_mid();
        req(4'h0, 32'h0000_0020, 0, "pre_reset_rd");
        #1;
        resetn = 0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h expected 0", rdata); end
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL async_led: got %h expected 0", led); end
        @(negedge clk);
        en = 1; we = 4'hF; addr = 32'h0000_0020; wdata = 32'h22222222;
        @(posedge clk);
        #1;
        addr = 32'hBFAF_0000;
        @(posedge clk);
        #1;
        en = 0; we = 0;
        @(negedge clk);
        resetn = 1;
        model_reset();
        req(4'h0, 32'h0000_0020, 0, "ram_survives_reset");
        req(4'h0, 32'hBFAF_0004, 0, "timer_after_reset");
        checks++;
        if (led !== 16'h0) begin errors++; $display("FAIL led_after_reset: got %h expected 0", led); end
    endtask

    task automatic test_wcnt();
        req(4'hF, 32'h0000_0040, 32'h01020304, "wc_w1");
        req(4'b0001, 32'h0000_0044, 32'h000000FF, "wc_w2");
        req(4'hF, 32'hBFAF_0008, 32'h0BADF00D, "wc_mmio");
        req(4'b1000, 32'h0000_0040, 32'hAA000000, "wc_w3");
        req(4'h0, 32'hBFAF_000C, 0, "wcnt_three");
        checks++;
        if (rdata !== (WCNT_ON ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL wcnt_const: got %h expected %h", rdata, WCNT_ON ? 32'd3 : 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_mmio();
        test_random();
        test_reset_mid();
        test_wcnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
